// File: rtl/datapath_run_ctrl_pkg.sv
// Shared constants for the datapath run/reset sequencer: state encoding and default timing.
package datapath_run_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StReset    = 3'd1,
    StRun      = 3'd2,
    StStepWait = 3'd3,
    StStep     = 3'd4,
    StDone     = 3'd5
  } run_state_e;

  localparam int unsigned DefaultRstCycles = 4;
  localparam int unsigned DefaultMaxCycles = 1000;

endpackage

// File: rtl/datapath_run_ctrl_rise_detect.sv
// Registered rising-edge detector with synchronous reset; rise is high while din=1 after a 0 sample.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= din;
    end
  end

  assign rise = din & ~prev_q;

endmodule

// File: rtl/datapath_run_ctrl.sv
// Run/reset sequencer for the single-cycle datapath: timed core reset, free-run or single-step
// execution enable, stop on halt or cycle budget, with cycle count and final PC reporting.
module datapath_run_ctrl
  import datapath_run_ctrl_pkg::*;
#(
  parameter int unsigned RST_CYCLES = DefaultRstCycles,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned MAX_CYCLES = DefaultMaxCycles,
  parameter int unsigned PC_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step_mode,
  input  logic             step_req,
  input  logic             halt_req,
  input  logic [PC_W-1:0]  pc_in,
  output logic             core_rst,
  output logic             core_en,
  output logic [CNT_W-1:0] cycle_count,
  output logic             done,
  output logic             timeout,
  output logic [PC_W-1:0]  last_pc
);

  localparam int unsigned RcW = $clog2(RST_CYCLES + 1);
  localparam bit BudgetOn = (MAX_CYCLES != 0);
  // Budget is checked against the pre-increment count so the triggering cycle is counted.
  localparam logic [CNT_W-1:0] BudgetLast = CNT_W'(MAX_CYCLES - 1);

  run_state_e       state_q;
  logic [RcW-1:0]   rst_cnt_q;
  logic [CNT_W-1:0] cycle_count_q;
  logic             timeout_q;
  logic [PC_W-1:0]  last_pc_q;

  logic             step_rise;
  logic [CNT_W-1:0] count_inc;
  logic             hit_budget;

  rise_detect u_step_rise (
    .clk  (clk),
    .rst  (rst),
    .din  (step_req),
    .rise (step_rise)
  );

  assign count_inc  = (&cycle_count_q) ? cycle_count_q : cycle_count_q + CNT_W'(1);
  assign hit_budget = BudgetOn && (cycle_count_q == BudgetLast);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      rst_cnt_q     <= '0;
      cycle_count_q <= '0;
      timeout_q     <= 1'b0;
      last_pc_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q       <= StReset;
            rst_cnt_q     <= RcW'(RST_CYCLES);
            cycle_count_q <= '0;
          end
        end
        StReset: begin
          if (rst_cnt_q == RcW'(1)) begin
            state_q <= step_mode ? StStepWait : StRun;
          end else begin
            rst_cnt_q <= rst_cnt_q - RcW'(1);
          end
        end
        StRun, StStep: begin
          cycle_count_q <= count_inc;
          if (halt_req) begin
            state_q   <= StDone;
            timeout_q <= 1'b0;
            last_pc_q <= pc_in;
          end else if (hit_budget) begin
            state_q   <= StDone;
            timeout_q <= 1'b1;
            last_pc_q <= pc_in;
          end else if (state_q == StStep || step_mode) begin
            state_q <= StStepWait;
          end
        end
        StStepWait: begin
          if (!step_mode) begin
            state_q <= StRun;
          end else if (step_rise) begin
            state_q <= StStep;
          end
        end
        StDone: begin
          if (start) begin
            state_q       <= StReset;
            rst_cnt_q     <= RcW'(RST_CYCLES);
            cycle_count_q <= '0;
            timeout_q     <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign core_rst    = (state_q == StIdle) || (state_q == StReset);
  assign core_en     = (state_q == StRun) || (state_q == StStep);
  assign done        = (state_q == StDone);
  assign cycle_count = cycle_count_q;
  assign timeout     = timeout_q;
  assign last_pc     = last_pc_q;

endmodule

// File: doc/datapath_run_ctrl.md
Name: datapath_run_ctrl

Overview:
- Parametrised run/reset controller for the single-cycle datapath.
- Replaces hand-timed reset pulses and free-running clocks with a deterministic sequencer. It issues a core reset of configurable length, then gates execution with a clock-enable.
- Supports free-run and single-step modes, stops on a halt request or a cycle budget, and reports cycle count and final PC.
- Sits between the top level or bench and the Datapath core's reset and enable inputs.

Parameters:
- RST_CYCLES, 4, number of cycles core_rst is held high after start (≥1).
- CNT_W, 32, width of cycle_count.
- MAX_CYCLES, 1000, run budget in enabled cycles; 0 = unlimited.
- PC_W, 32, width of pc_in and last_pc.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a run; sampled only in IDLE or DONE.
- step_mode  in  1  1 = single-step, 0 = free-run.
- step_req  in  1  step request; rising-edge detected internally.
- halt_req  in  1  halt from core (e.g. halt opcode decoded); sampled only when core_en=1.
- pc_in  in  PC_W  current core PC.
- core_rst  out  1  reset to datapath.
- core_en  out  1  execute enable to datapath.
- cycle_count  out  CNT_W  enabled cycles in the current run.
- done  out  1  run finished.
- timeout  out  1  run ended on MAX_CYCLES, not on halt.
- last_pc  out  PC_W  pc_in captured on DONE entry.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst).
- Reset values: state=IDLE, core_rst=1, core_en=0, cycle_count=0, done=0, timeout=0, last_pc=0, step edge-detector history=0.
- rst overrides everything, including mid-run; effect is visible on the cycle after the edge where it is sampled high.
- Outputs are decoded from registered state or registers only; there is no combinational path from inputs to outputs.
- States: IDLE, RESET, RUN, STEP_WAIT, STEP, DONE.
- IDLE:
  - core_rst=1, core_en=0.
  - start=1 → RESET, rst_cnt loaded with RST_CYCLES, cycle_count cleared.
- RESET:
  - core_rst=1, core_en=0 for exactly RST_CYCLES cycles.
  - Then → STEP_WAIT if step_mode=1, else → RUN.
- RUN:
  - core_rst=0, core_en=1.
  - Each cycle: cycle_count += 1, saturating at all-ones.
  - Transition priority: halt_req → DONE (timeout=0); else MAX_CYCLES≠0 and cycle_count==MAX_CYCLES-1 → DONE (timeout=1); else step_mode=1 → STEP_WAIT.
  - The cycle in which halt_req or the budget triggers is counted.
- STEP_WAIT:
  - core_en=0.
  - step_mode=0 → RUN.
  - Rising edge on step_req (step_req=1 and previous sample 0) → STEP.
  - step_req held high yields exactly one step.
- STEP:
  - core_en=1 for exactly one cycle; counts as in RUN.
  - Same halt and budget checks as RUN; otherwise → STEP_WAIT.
- DONE:
  - core_rst=0, core_en=0, done=1; timeout and last_pc hold.
  - start=1 → RESET; clears done, timeout and cycle_count.
- start is ignored in RESET, RUN, STEP_WAIT and STEP.
- Latency: start sampled at edge k → core_rst=1 from k+1 to k+RST_CYCLES. The first core_en=1 cycle begins at edge k+1+RST_CYCLES (free-run).
- last_pc is captured from pc_in on the edge entering DONE.
- Halt and budget in the same cycle: halt wins, timeout=0.

Decomposition:
- Shared datapath constants file:
  - state encoding localparams (IDLE=0 … DONE=5, 3-bit);
  - default RST_CYCLES and MAX_CYCLES.
- One sub-module: rise_detect (1-bit registered edge detector, synchronous reset), used for step_req.
- Everything else stays in datapath_run_ctrl.

Test Plan:
1. Reset then start (RST_CYCLES=4, step_mode=0) → core_rst high exactly 4 cycles after start. core_en rises the next cycle; cycle_count increments 1,2,3… each cycle.
2. Free-run with halt_req pulsed at the 10th enabled cycle → done=1, timeout=0, cycle_count=10, core_en=0, last_pc equals pc_in on that edge.
3. MAX_CYCLES=20, no halt → done after exactly 20 enabled cycles, timeout=1, cycle_count=20. Repeat with halt_req on cycle 20 → timeout=0.
4. step_mode=1, step_req held high 5 cycles, then three 1-cycle pulses → exactly 4 single-cycle core_en pulses, cycle_count=4. Deassert step_mode → free-run resumes next cycle.
5. rst asserted mid-RUN at cycle_count=7 → next cycle: state IDLE, core_rst=1, core_en=0, cycle_count=0. start during RUN/RESET has no effect.
6. From DONE, start again → done/timeout clear, fresh RST_CYCLES reset, cycle_count restarts from 0. MAX_CYCLES=0 with no halt runs past 1000 cycles without done.
